mem_stream_tx: RTL
==================

# mem_stream_tx

Transmitter end of the core's valid/ready input streams (a_input/a_valid/a_ready, b_input/b_valid/b_ready). On `start` it reads a contiguous block of words from external memory and presents them, in address order, on a valid/ready stream. It sustains one word per cycle under no backpressure and never drops or duplicates a word under backpressure. The top system instantiates one per input stream: one for the feature-map stream, one for the kernel stream.

## Interface
- IO_DATA_WIDTH, 16, width of streamed words
- EXT_MEM_WIDTH, 32, width of external memory words
- EXT_MEM_HEIGHT, 1<<20, memory depth in words; ADDR_WIDTH = $clog2(EXT_MEM_HEIGHT) (derived)
- LEN_WIDTH, 21, width of the transfer-length field

Ports:
- clk  in  1  clock; all logic rising-edge
- arst_n_in  in  1  asynchronous active-low reset
- start  in  1  launch a transfer; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first word address; sampled with start
- length  in  LEN_WIDTH  number of words to send; sampled with start
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer completion
- mem_read_en  out  1  memory read request
- mem_read_addr  out  ADDR_WIDTH  memory read address
- mem_read_data  in  EXT_MEM_WIDTH  read data, valid exactly one cycle after mem_read_en
- stream_data  out  IO_DATA_WIDTH  output word
- stream_valid  out  1  stream_data valid
- stream_ready  in  1  sink accepts the word

## Operation
- States:
  - IDLE: start=1 captures base_addr/length and zeroes issue and send counters. If length=0, go to DONE; else go to RUN.
  - RUN: issue reads and drain the FIFO. When send count reaches length, go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- start outside IDLE is ignored; captured parameters cannot change mid-transfer.
- Read issue: mem_read_addr = (base + issue_count) mod EXT_MEM_HEIGHT, so the address wraps to 0 past the top of memory.
  - A read is issued in RUN when issue_count < length and (fifo_count + inflight < 2, or fifo_count + inflight = 2 and a stream handshake occurs this cycle).
  - mem_read_en=0 otherwise; mem_read_addr is don't-care when mem_read_en=0.
- Return path: mem_read_data[IO_DATA_WIDTH-1:0] is written into a 2-entry FIFO on the cycle the data is valid. Upper bits are discarded with no sign handling.
- Output: stream_valid = FIFO non-empty; stream_data = FIFO head.
  - Handshake = stream_valid & stream_ready; the FIFO pops on a handshake.
  - Once stream_valid=1, it and stream_data stay stable until the handshake.
- Simultaneous FIFO push and pop in one cycle is legal and leaves the count unchanged. The credit rule makes FIFO overflow impossible; overflow is an assertion error.
- busy=1 in RUN and DONE, 0 in IDLE.

## Timing
- Reset values (asynchronous, immediate): state IDLE; busy=0, done=0, mem_read_en=0, mem_read_addr=0, stream_valid=0, stream_data=0; counters and FIFO cleared.
- Reset mid-transfer aborts immediately: any in-flight read data is discarded and no done pulse is issued.
- Latency: start high in cycle 0 → mem_read_en in cycle 1 → data returns in cycle 2 → stream_valid in cycle 3.
- Throughput: with stream_ready held 1, one word per cycle from cycle 3. N words complete their handshakes in cycles 3..N+2.
- done pulses in the cycle after the last handshake; busy falls together with done. For length=0, done pulses in cycle 1 and no read is issued.
- Backpressure: while stream_ready=0, at most 2 words are buffered or in flight, and reads stop until credit frees. Releasing ready resumes one word per cycle after one bubble at most.
- A new start is accepted in the cycle after done, at the earliest.

## Test plan
- Basic: mem[100..103]=0x0001_1111, 0x0002_2222, 0x0003_3333, 0x0004_4444; base=100, len=4, ready=1 → stream 0x1111, 0x2222, 0x3333, 0x4444 in cycles 3–6; done in cycle 7; exactly 4 reads.
- Backpressure: len=8, ready toggled randomly with 50% duty → the 8 words arrive in order with no loss or duplicates; data stays stable while valid & !ready; never more than 2 outstanding words.
- Zero length: base=5, len=0 → no mem_read_en, no stream_valid; done in cycle 1.
- Wrap: base=EXT_MEM_HEIGHT-2, len=4 → read addresses 0xFFFFE, 0xFFFFF, 0x0, 0x1, with the data in that order.
- Start while busy: second start with different base/len during a len=6 transfer → ignored; only the original 6 words are sent; one done pulse.
- Reset mid-transfer: assert arst_n_in after 2 handshakes of len=10 → all outputs at reset values immediately. After release, a new len=3 transfer sends exactly 3 correct words.

Source files
------------

// File: rtl/mem_stream_tx_if.sv
// -----------------------------------------------------------------------------
// mem_stream_tx_if
//   Bus bundle between mem_stream_tx and the blocks around it: the external
//   memory read port and the outgoing valid/ready word stream.
//
//   Signals:
//     mem_read_en    tx -> mem   read request
//     mem_read_addr  tx -> mem   read address
//     mem_read_data  mem -> tx   read data, valid one cycle after mem_read_en
//     stream_data    tx -> sink  output word
//     stream_valid   tx -> sink  stream_data valid
//     stream_ready   sink -> tx  sink accepts the word
//
//   Modports: master = transmitter side, slave = memory + sink side.
// -----------------------------------------------------------------------------
interface mem_stream_tx_if #(
    parameter int IO_DATA_WIDTH  = 16,
    parameter int EXT_MEM_WIDTH  = 32,
    parameter int EXT_MEM_HEIGHT = 1 << 20
);
    localparam int ADDR_WIDTH = $clog2(EXT_MEM_HEIGHT);

    logic                     mem_read_en;
    logic [ADDR_WIDTH-1:0]    mem_read_addr;
    logic [EXT_MEM_WIDTH-1:0] mem_read_data;
    logic [IO_DATA_WIDTH-1:0] stream_data;
    logic                     stream_valid;
    logic                     stream_ready;

    modport master (
        output mem_read_en,
        output mem_read_addr,
        input  mem_read_data,
        output stream_data,
        output stream_valid,
        input  stream_ready
    );

    modport slave (
        input  mem_read_en,
        input  mem_read_addr,
        output mem_read_data,
        input  stream_data,
        input  stream_valid,
        output stream_ready
    );
endinterface

// File: rtl/mem_stream_tx.sv
// -----------------------------------------------------------------------------
// mem_stream_tx
//   On start, reads a contiguous block of words from external memory and
//   sends them in address order on a valid/ready stream, one word per cycle
//   when the sink never stalls.
//
//   Ports:
//     clk          clock, rising edge
//     arst_n_in    asynchronous active-low reset
//     start        launch a transfer (sampled only when idle)
//     base_addr    first word address, sampled with start
//     length       number of words, sampled with start
//     busy         transfer in progress (RUN and DONE)
//     done         one-cycle pulse at completion
//     o_dbg_state  current FSM state, for observation only
//     bus          memory read port + output stream (master modport)
//
//   Stream handshake: a word transfers in every cycle where stream_valid and
//   stream_ready are both 1. Once stream_valid rises, stream_valid and
//   stream_data hold until that handshake; stream_ready may change freely.
// -----------------------------------------------------------------------------
module mem_stream_tx #(
    parameter int IO_DATA_WIDTH  = 16,
    parameter int EXT_MEM_WIDTH  = 32,
    parameter int EXT_MEM_HEIGHT = 1 << 20,
    parameter int LEN_WIDTH      = 21,
    localparam int ADDR_WIDTH    = $clog2(EXT_MEM_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  arst_n_in,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            o_dbg_state,
    mem_stream_tx_if.master       bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   r_state;
    logic                     r_busy;
    logic                     r_done;
    logic [LEN_WIDTH-1:0]     r_len;
    logic [LEN_WIDTH-1:0]     r_issue_cnt;
    logic [LEN_WIDTH-1:0]     r_send_cnt;
    logic [ADDR_WIDTH-1:0]    r_addr;

    // Two-entry return FIFO plus one bit tracking the read in flight.
    logic [IO_DATA_WIDTH-1:0] r_fifo [2];
    logic                     r_rd_ptr;
    logic                     r_wr_ptr;
    logic [1:0]               r_count;
    logic                     r_inflight;

    logic                     w_pop;
    logic                     w_push;
    logic                     w_issue;
    logic [1:0]               w_occ;
    logic                     w_unused_hi;

    assign w_pop  = (r_count != 2'd0) && bus.stream_ready;
    assign w_push = r_inflight;
    assign w_occ  = r_count + {1'b0, r_inflight};

    // Credit: at most two words buffered or in flight; a pop this cycle frees
    // a slot in time for data returning next cycle, which keeps full rate.
    assign w_issue = (r_state == S_RUN) && (r_issue_cnt < r_len) &&
                     ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop));

    assign bus.mem_read_en   = w_issue;
    assign bus.mem_read_addr = w_issue ? r_addr : '0;
    assign bus.stream_valid  = (r_count != 2'd0);
    assign bus.stream_data   = r_fifo[r_rd_ptr];

    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;

    // Only the low IO_DATA_WIDTH bits of a memory word are streamed.
    assign w_unused_hi = ^bus.mem_read_data[EXT_MEM_WIDTH-1:IO_DATA_WIDTH];

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_len       <= '0;
            r_issue_cnt <= '0;
            r_send_cnt  <= '0;
            r_addr      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_len       <= length;
                        r_addr      <= base_addr;
                        r_issue_cnt <= '0;
                        r_send_cnt  <= '0;
                        r_busy      <= 1'b1;
                        if (length == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_issue_cnt <= r_issue_cnt + 1'b1;
                        // Explicit wrap so non-power-of-two depths also work.
                        if (r_addr == ADDR_WIDTH'(EXT_MEM_HEIGHT - 1))
                            r_addr <= '0;
                        else
                            r_addr <= r_addr + 1'b1;
                    end
                    if (w_pop) begin
                        r_send_cnt <= r_send_cnt + 1'b1;
                        if (LEN_WIDTH'(r_send_cnt + 1'b1) == r_len) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_push) begin
                r_fifo[r_wr_ptr] <= bus.mem_read_data[IO_DATA_WIDTH-1:0];
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!arst_n_in)
        !(w_push && !w_pop && (r_count == 2'd2)));

endmodule
